// File: rtl/free_list.sv
// Circular free list of physical register tags. Hands out a tag per dispatch,
// reclaims the retiring instruction's old tag, and restores the allocation head
// from a per-ROB-entry checkpoint on branch rollback.
module free_list #(
    parameter int unsigned NUM_PR   = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned NUM_ROB  = 32,
    localparam int unsigned FL_DEPTH = NUM_PR - NUM_ARCH,
    localparam int unsigned PR_W     = $clog2(NUM_PR),
    localparam int unsigned ROB_W    = $clog2(NUM_ROB),
    localparam int unsigned IDX_W    = $clog2(FL_DEPTH),
    localparam int unsigned PTR_W    = IDX_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             dispatch_en,
    input  logic [ROB_W-1:0] dispatch_rob_idx,
    input  logic             retire_en,
    input  logic [PR_W-1:0]  retire_Told_idx,
    input  logic             rollback_en,
    input  logic [ROB_W-1:0] rollback_rob_idx,
    output logic [PR_W-1:0]  T_idx,
    output logic             FL_valid,
    output logic [PTR_W-1:0] free_count,
    output logic             overflow_err
);

    // Index arithmetic relies on the pointer index field wrapping naturally.
    if ((FL_DEPTH == 0) || ((FL_DEPTH & (FL_DEPTH - 1)) != 0)) begin : gen_bad_depth
        $error("free_list: NUM_PR - NUM_ARCH must be a non-zero power of two");
    end

    localparam logic [PTR_W-1:0] FullCount = PTR_W'(FL_DEPTH);

    logic [PR_W-1:0]  tags_q [FL_DEPTH];
    logic [PTR_W-1:0] ckpt_q [NUM_ROB];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] free_count_q, free_count_d;
    logic             overflow_q, overflow_d;

    logic [PTR_W-1:0] count;
    logic             is_empty;
    logic             is_full;
    logic             pop;
    logic             push;
    logic             do_rollback;
    logic [PTR_W-1:0] head_inc;

    // Occupancy and the qualified pop/push/rollback strobes.
    always_comb begin
        count       = tail_q - head_q;
        is_empty    = (count == '0);
        is_full     = (count == FullCount);
        do_rollback = en & rollback_en;
        // Rollback wins over dispatch; an empty list never bypasses a retiring tag.
        pop         = en & dispatch_en & ~is_empty & ~rollback_en;
        push        = en & retire_en & ~is_full;
        head_inc    = head_q + PTR_W'(1);
    end

    // Next-state for pointers, registered count and the overflow pulse.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        overflow_d   = overflow_q;
        if (do_rollback) begin
            head_d = ckpt_q[rollback_rob_idx];
        end else if (pop) begin
            head_d = head_inc;
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (en) begin
            overflow_d = retire_en & is_full;
        end
        free_count_d = tail_d - head_d;
    end

    // Pointer, count and error-flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q       <= '0;
            tail_q       <= FullCount;
            free_count_q <= FullCount;
            overflow_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
            overflow_q   <= overflow_d;
        end
    end

    // Tag storage: seeded with the tags beyond the architectural mapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(FL_DEPTH); i++) begin
                tags_q[i] <= PR_W'(NUM_ARCH + i);
            end
        end else if (push) begin
            tags_q[tail_q[IDX_W-1:0]] <= retire_Told_idx;
        end
    end

    // Checkpoint the post-allocation head for the ROB slot taking the tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_ROB); i++) begin
                ckpt_q[i] <= '0;
            end
        end else if (pop) begin
            ckpt_q[dispatch_rob_idx] <= head_inc;
        end
    end

    // Outputs: head tag is combinational so allocation has no extra latency.
    always_comb begin
        T_idx        = tags_q[head_q[IDX_W-1:0]];
        free_count   = free_count_q;
        FL_valid     = (free_count_q != '0) & ~rollback_en;
        overflow_err = overflow_q;
    end

    // The list can never hold more free tags than it has slots.
    property p_count_bounded;
        @(posedge clock) disable iff (reset) (free_count_q <= FullCount);
    endproperty
    a_count_bounded: assert property (p_count_bounded);

    // A successful push can only occur while not full.
    property p_no_push_when_full;
        @(posedge clock) disable iff (reset) (is_full |-> ~push);
    endproperty
    a_no_push_when_full: assert property (p_no_push_when_full);

endmodule
